gcd_stein_core: RTL and testbench
=================================

Name: gcd_stein_core

Overview:
- Parametrised iterative GCD engine using the binary (Stein) algorithm. It needs only shifts, compares and subtracts, with no divider.
- Operand width is a parameter. Input and output use valid/ready handshakes.
- Reports, per result, a coprime flag and the iteration cycle count.
- Sits as a compute leaf behind a command/response interface; one operation in flight at a time.

Parameters:
- WIDTH, 32, operand and result width in bits (≥2).
- CNT_W, $clog2(4*WIDTH+8), width of the cycles output; must hold the worst-case latency.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  engine can accept operands.
- x  in  WIDTH  operand A, unsigned.
- y  in  WIDTH  operand B, unsigned.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- gcd  out  WIDTH  result.
- coprime  out  1  high when gcd==1.
- cycles  out  CNT_W  clock edges from acceptance to DONE entry.

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n; all state clears immediately on rst_n low, regardless of clk.
- Reset values: state=IDLE, in_ready=1, out_valid=0, gcd=0, coprime=0, cycles=0. Internal a, b and k are all 0.
- Handshake:
  - Transfer occurs on a clk edge where valid&&ready.
  - in_ready=1 only in IDLE. out_valid=1 only in DONE.
  - x and y are sampled only on the acceptance edge; later input changes are ignored.
- States and transitions (one action per edge):
  - IDLE: on in_valid, load a=x, b=y, k=0, cnt=0.
    - If x==0 or y==0: result=x|y, go to DONE on the same edge, cycles=0.
    - Otherwise go to SHIFT.
  - SHIFT: if a[0]==0 and b[0]==0, shift a>>=1, b>>=1, k++ and stay. Otherwise go to ODD_A.
  - ODD_A: if a[0]==0, a>>=1 and stay. Otherwise go to LOOP. Invariant from here on: a is odd.
  - LOOP, evaluated in this priority order:
    - b==0: go to FINISH.
    - b[0]==0: b>>=1.
    - a>b: a<=b, b<=a-b.
    - otherwise: b<=b-a.
  - FINISH: gcd<=a<<k (fits in WIDTH because the true gcd ≤ min(x,y)). coprime<=(a==1 && k==0). Go to DONE.
  - DONE: hold gcd, coprime and cycles stable while out_valid=1. When out_ready=1, go to IDLE with out_valid=0.
- Cycle counter:
  - cnt increments on every edge spent in SHIFT, ODD_A, LOOP and FINISH.
  - cycles<=cnt+1 is registered on the FINISH edge.
  - cnt saturates at its maximum and never wraps.
- Latency bound: cycles ≤ 4*WIDTH+4 for any nonzero operands.
- No pipelining. A new operation is accepted only in IDLE, so there is at least one IDLE cycle between results.
- Boundaries:
  - gcd(0,0)=0, coprime=0.
  - gcd(0,n)=n, gcd(n,0)=n, in zero LOOP cycles.
  - gcd(n,n)=n.
  - All-ones operands are legal; subtraction never underflows because the smaller value is always the one subtracted.
- Reset mid-operation: asserting rst_n low in any state aborts immediately. Any result not yet handed off is discarded, and outputs return to reset values.
- out_ready held high in IDLE or busy states has no effect. in_valid held high while busy is ignored and not queued.

Test Plan:
- Reset then x=1, y=1 → in_ready drops for 6 cycles. Then out_valid=1 with gcd=1, coprime=1, cycles=5.
- x=48, y=18, out_ready=1 → gcd=6, coprime=0, cycles ≤ 4*WIDTH+4; x=35, y=64 → gcd=1, coprime=1.
- Zeros:
  - x=0, y=0 → gcd=0, cycles=0, out_valid on the cycle after acceptance.
  - x=0, y=12 → gcd=12.
  - x=12, y=0 → gcd=12.
- WIDTH=32 with x=0xFFFFFFFF, y=0xFFFFFFFE → gcd=1. Then x=0x80000000, y=0x40000000 → gcd=0x40000000, coprime=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → gcd, coprime and cycles stay stable and in_ready stays 0. Change x and y during the stall → the result is unchanged.
- Reset mid-operation: drop rst_n asynchronously in LOOP (between edges) → out_valid=0 and in_ready=1 immediately. After release, x=21, y=14 → gcd=7.

Source files
------------

// File: rtl/gcd_stein_core_if.sv
// Command/response bundle for the binary GCD engine: operand pair in, result out.
// Both directions use valid/ready handshakes; clock and reset travel separately.
interface gcd_stein_core_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(4 * WIDTH + 8)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] gcd;
  logic             coprime;
  logic [CNT_W-1:0] cycles;

  modport master (
    output in_valid, x, y, out_ready,
    input  in_ready, out_valid, gcd, coprime, cycles
  );

  modport slave (
    input  in_valid, x, y, out_ready,
    output in_ready, out_valid, gcd, coprime, cycles
  );
endinterface

// File: rtl/gcd_stein_core.sv
// Iterative binary (Stein) GCD engine: shifts, compares and subtracts only.
// One operation in flight; reports gcd, a coprime flag and the iteration cycle count.
module gcd_stein_core #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(4 * WIDTH + 8)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gcd_stein_core_if.slave      gcd_if
);

  localparam int K_W = $clog2(WIDTH) + 1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SHIFT  = 3'd1;
  localparam logic [2:0] ST_ODD_A  = 3'd2;
  localparam logic [2:0] ST_LOOP   = 3'd3;
  localparam logic [2:0] ST_FINISH = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  logic [2:0]       r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, w_a_nxt;
  logic [WIDTH-1:0] r_b, w_b_nxt;
  logic [K_W-1:0]   r_k, w_k_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_gcd, w_gcd_nxt;
  logic             r_coprime, w_coprime_nxt;
  logic [CNT_W-1:0] r_cycles, w_cycles_nxt;

  logic [CNT_W-1:0] w_cnt_inc;
  logic [WIDTH-1:0] w_xy_or;

  // Saturating increment; also reused as the registered cycle count on FINISH.
  assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;
  assign w_xy_or   = gcd_if.x | gcd_if.y;

  always_comb begin
    w_state_nxt   = r_state;
    w_a_nxt       = r_a;
    w_b_nxt       = r_b;
    w_k_nxt       = r_k;
    w_cnt_nxt     = r_cnt;
    w_gcd_nxt     = r_gcd;
    w_coprime_nxt = r_coprime;
    w_cycles_nxt  = r_cycles;

    case (r_state)
      ST_IDLE: begin
        if (gcd_if.in_valid) begin
          w_a_nxt   = gcd_if.x;
          w_b_nxt   = gcd_if.y;
          w_k_nxt   = '0;
          w_cnt_nxt = '0;
          if (gcd_if.x == '0 || gcd_if.y == '0) begin
            // A zero operand makes the other one the answer directly.
            w_gcd_nxt     = w_xy_or;
            w_coprime_nxt = (w_xy_or == WIDTH'(1));
            w_cycles_nxt  = '0;
            w_state_nxt   = ST_DONE;
          end else begin
            w_state_nxt = ST_SHIFT;
          end
        end
      end

      ST_SHIFT: begin
        w_cnt_nxt = w_cnt_inc;
        if (!r_a[0] && !r_b[0]) begin
          w_a_nxt = r_a >> 1;
          w_b_nxt = r_b >> 1;
          w_k_nxt = r_k + 1'b1;
        end else begin
          w_state_nxt = ST_ODD_A;
        end
      end

      ST_ODD_A: begin
        w_cnt_nxt = w_cnt_inc;
        if (!r_a[0]) begin
          w_a_nxt = r_a >> 1;
        end else begin
          w_state_nxt = ST_LOOP;
        end
      end

      ST_LOOP: begin
        // a stays odd here, so the subtraction result is always even.
        w_cnt_nxt = w_cnt_inc;
        if (r_b == '0) begin
          w_state_nxt = ST_FINISH;
        end else if (!r_b[0]) begin
          w_b_nxt = r_b >> 1;
        end else if (r_a > r_b) begin
          w_a_nxt = r_b;
          w_b_nxt = r_a - r_b;
        end else begin
          w_b_nxt = r_b - r_a;
        end
      end

      ST_FINISH: begin
        w_cnt_nxt     = w_cnt_inc;
        w_gcd_nxt     = r_a << r_k;
        w_coprime_nxt = (r_a == WIDTH'(1)) && (r_k == '0);
        w_cycles_nxt  = w_cnt_inc;
        w_state_nxt   = ST_DONE;
      end

      ST_DONE: begin
        if (gcd_if.out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_k       <= '0;
      r_cnt     <= '0;
      r_gcd     <= '0;
      r_coprime <= 1'b0;
      r_cycles  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_a       <= w_a_nxt;
      r_b       <= w_b_nxt;
      r_k       <= w_k_nxt;
      r_cnt     <= w_cnt_nxt;
      r_gcd     <= w_gcd_nxt;
      r_coprime <= w_coprime_nxt;
      r_cycles  <= w_cycles_nxt;
    end
  end

  assign gcd_if.in_ready  = (r_state == ST_IDLE);
  assign gcd_if.out_valid = (r_state == ST_DONE);
  assign gcd_if.gcd       = r_gcd;
  assign gcd_if.coprime   = r_coprime;
  assign gcd_if.cycles    = r_cycles;

endmodule

// File: tb/tb_gcd_stein_core.sv
// Directed self-checking bench for gcd_stein_core with hand-computed expectations.
module tb_gcd_stein_core;
  localparam int WIDTH = 32;
  localparam int CNT_W = $clog2(4 * WIDTH + 8);
  localparam int MAX_LAT = 4 * WIDTH + 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  gcd_stein_core_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  gcd_stein_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .gcd_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present operands for one edge; assumes the engine is idle.
  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clk);
    bus.x = a;
    bus.y = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // Returns on the first negedge with out_valid; lat counts the busy negedges before it.
  task automatic wait_valid(output int lat, output bit timeout);
    lat = 0;
    timeout = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        timeout = 1'b0;
        break;
      end
      lat++;
    end
  endtask

  task automatic ack();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks += 5;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    if (bus.gcd !== '0) begin errors++; $display("FAIL reset_gcd got %0h want 0", bus.gcd); end
    if (bus.coprime !== 1'b0) begin errors++; $display("FAIL reset_coprime got %b want 0", bus.coprime); end
    if (bus.cycles !== '0) begin errors++; $display("FAIL reset_cycles got %0d want 0", bus.cycles); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // gcd(1,1): SHIFT, ODD_A, LOOP, LOOP, FINISH, then DONE -> six cycles without in_ready.
  task automatic test_basic();
    int  low;
    bit  seen;
    low = 0;
    seen = 1'b0;
    start_op(32'd1, 32'd1);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!bus.in_ready) low++;
      if (bus.out_valid) begin
        seen = 1'b1;
        checks += 3;
        if (bus.gcd !== 32'd1) begin errors++; $display("FAIL basic_gcd got %0d want 1", bus.gcd); end
        if (bus.coprime !== 1'b1) begin errors++; $display("FAIL basic_coprime got %b want 1", bus.coprime); end
        if (bus.cycles !== 8'd5) begin errors++; $display("FAIL basic_cycles got %0d want 5", bus.cycles); end
        ack();
        break;
      end
    end
    checks += 3;
    if (!seen) begin errors++; $display("FAIL basic_timeout got no out_valid want out_valid"); end
    if (low !== 6) begin errors++; $display("FAIL basic_busy_cycles got %0d want 6", low); end
    @(negedge clk);
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_after got %b want 1", bus.in_ready); end
  endtask

  task automatic test_values();
    logic [WIDTH-1:0] vx [2] = '{32'd48, 32'd35};
    logic [WIDTH-1:0] vy [2] = '{32'd18, 32'd64};
    logic [WIDTH-1:0] vg [2] = '{32'd6, 32'd1};
    logic             vc [2] = '{1'b0, 1'b1};
    int               vn [2] = '{11, 18};
    int lat;
    bit to;
    for (int i = 0; i < 2; i++) begin
      start_op(vx[i], vy[i]);
      wait_valid(lat, to);
      checks += 5;
      if (to) begin errors++; $display("FAIL values_timeout[%0d] got none want out_valid", i); end
      if (bus.gcd !== vg[i]) begin errors++; $display("FAIL values_gcd[%0d] got %0d want %0d", i, bus.gcd, vg[i]); end
      if (bus.coprime !== vc[i]) begin errors++; $display("FAIL values_coprime[%0d] got %b want %b", i, bus.coprime, vc[i]); end
      if (int'(bus.cycles) !== vn[i]) begin errors++; $display("FAIL values_cycles[%0d] got %0d want %0d", i, bus.cycles, vn[i]); end
      if (int'(bus.cycles) > MAX_LAT) begin errors++; $display("FAIL values_bound[%0d] got %0d want <= %0d", i, bus.cycles, MAX_LAT); end
      ack();
    end
  endtask

  task automatic test_zeros();
    logic [WIDTH-1:0] vx [3] = '{32'd0, 32'd0, 32'd12};
    logic [WIDTH-1:0] vy [3] = '{32'd0, 32'd12, 32'd0};
    logic [WIDTH-1:0] vg [3] = '{32'd0, 32'd12, 32'd12};
    int lat;
    bit to;
    for (int i = 0; i < 3; i++) begin
      start_op(vx[i], vy[i]);
      wait_valid(lat, to);
      checks += 5;
      if (to) begin errors++; $display("FAIL zeros_timeout[%0d] got none want out_valid", i); end
      if (lat !== 0) begin errors++; $display("FAIL zeros_latency[%0d] got %0d want 0", i, lat); end
      if (bus.gcd !== vg[i]) begin errors++; $display("FAIL zeros_gcd[%0d] got %0d want %0d", i, bus.gcd, vg[i]); end
      if (bus.coprime !== 1'b0) begin errors++; $display("FAIL zeros_coprime[%0d] got %b want 0", i, bus.coprime); end
      if (bus.cycles !== '0) begin errors++; $display("FAIL zeros_cycles[%0d] got %0d want 0", i, bus.cycles); end
      ack();
    end
  endtask

  task automatic test_wide();
    logic [WIDTH-1:0] vx [2] = '{32'hFFFF_FFFF, 32'h8000_0000};
    logic [WIDTH-1:0] vy [2] = '{32'hFFFF_FFFE, 32'h4000_0000};
    logic [WIDTH-1:0] vg [2] = '{32'd1, 32'h4000_0000};
    logic             vc [2] = '{1'b1, 1'b0};
    int lat;
    bit to;
    for (int i = 0; i < 2; i++) begin
      start_op(vx[i], vy[i]);
      wait_valid(lat, to);
      checks += 4;
      if (to) begin errors++; $display("FAIL wide_timeout[%0d] got none want out_valid", i); end
      if (bus.gcd !== vg[i]) begin errors++; $display("FAIL wide_gcd[%0d] got %0h want %0h", i, bus.gcd, vg[i]); end
      if (bus.coprime !== vc[i]) begin errors++; $display("FAIL wide_coprime[%0d] got %b want %b", i, bus.coprime, vc[i]); end
      if (int'(bus.cycles) > MAX_LAT) begin errors++; $display("FAIL wide_bound[%0d] got %0d want <= %0d", i, bus.cycles, MAX_LAT); end
      ack();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bit to;
    start_op(32'd48, 32'd18);
    wait_valid(lat, to);
    checks += 1;
    if (to) begin errors++; $display("FAIL bp_timeout got none want out_valid"); end
    for (int i = 0; i < 10; i++) begin
      bus.x = 32'd7 + i;
      bus.y = 32'd100 + i;
      bus.in_valid = 1'b1;
      @(negedge clk);
      checks += 5;
      if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %b want 1", i, bus.out_valid); end
      if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got %b want 0", i, bus.in_ready); end
      if (bus.gcd !== 32'd6) begin errors++; $display("FAIL bp_gcd[%0d] got %0d want 6", i, bus.gcd); end
      if (bus.coprime !== 1'b0) begin errors++; $display("FAIL bp_coprime[%0d] got %b want 0", i, bus.coprime); end
      if (bus.cycles !== 8'd11) begin errors++; $display("FAIL bp_cycles[%0d] got %0d want 11", i, bus.cycles); end
    end
    bus.in_valid = 1'b0;
    ack();
  endtask

  task automatic test_reset_mid();
    int lat;
    bit to;
    start_op(32'd35, 32'd64);
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks += 3;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got %b want 0", bus.out_valid); end
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready got %b want 1", bus.in_ready); end
    if (bus.cycles !== '0) begin errors++; $display("FAIL mid_cycles got %0d want 0", bus.cycles); end
    @(negedge clk);
    rst_n = 1'b1;
    start_op(32'd21, 32'd14);
    wait_valid(lat, to);
    checks += 3;
    if (to) begin errors++; $display("FAIL mid_timeout got none want out_valid"); end
    if (bus.gcd !== 32'd7) begin errors++; $display("FAIL mid_gcd got %0d want 7", bus.gcd); end
    if (bus.coprime !== 1'b0) begin errors++; $display("FAIL mid_coprime got %b want 0", bus.coprime); end
    ack();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.x = '0;
    bus.y = '0;
    test_reset();
    test_basic();
    test_values();
    test_zeros();
    test_wide();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
